fetch_unit: RTL and testbench

- Instruction fetch front end that sits directly upstream of the decode/register-read stage of the CPU.
- Generates sequential PCs and fetches instructions from instruction memory over a req/ack handshake.
- Buffers fetched {pc, inst} pairs in a small queue and presents them to decode over valid/ready.
- On a taken branch or jump (redirect), discards wrong-path instructions and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Contents:
//   XLEN          - architectural width of PCs and instruction words
//   PC_STEP       - byte distance between sequential instructions
//   fetch_state_e - fetch controller states
//   fetch_entry_t - one buffered {pc, inst} pair
//   align_pc()    - clears the byte-offset bits of an instruction address
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDiscard
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs for decode.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-low reset
//   push_i         - write push_data_i (ignored when full or flushing)
//   pop_i          - drop the head entry (ignored when empty or flushing)
//   flush_i        - empty the queue at the next edge; overrides push/pop
//   push_data_i    - entry to write
//   head_o         - oldest entry, all zeros when empty
//   count_o        - number of valid entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     push_data_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push = push_i && !flush_i && (count_q < CNT_W'(DEPTH));
        do_pop  = pop_i && !flush_i && (count_q != '0);
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; count_q gates everything that reads it.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end feeding the decode stage.
// Generates sequential PCs, fetches over a req/ack handshake, buffers {pc, inst}
// pairs and hands them to decode over valid/ready. A redirect flushes the buffer
// and restarts fetch at the target; a request already in flight is completed and
// its data dropped.
// Ports:
//   clk_i, rst_i       - clock, asynchronous active-low reset
//   start_i            - fetch enable; no new requests while low
//   redirect_i         - taken branch/jump pulse
//   redirect_pc_i      - redirect target (low two bits ignored)
//   imem_req_o         - instruction memory request
//   imem_addr_o        - request address, stable until ack
//   imem_ack_i         - request completes when imem_req_o && imem_ack_i
//   imem_data_i        - instruction word, valid with ack
//   inst_valid_o       - buffer head valid
//   inst_o, inst_pc_o  - head instruction and its PC (zero when empty)
//   inst_ready_i       - decode accepts the head
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic            req_q;
    logic [XLEN-1:0] addr_q;

    logic             hold;
    logic             push;
    logic             pop;
    logic             issue;
    logic [XLEN-1:0]  pc_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    always_comb begin
        // hold: request stays outstanding into the next cycle
        hold = req_q && !imem_ack_i;
        // Data is kept only in RUN and only when no redirect makes it wrong-path.
        push = req_q && imem_ack_i && (state_q == StRun) && !redirect_i;
        pop  = inst_valid_o && inst_ready_i;

        if (redirect_i) begin
            pc_next = align_pc(redirect_pc_i);
        end else if (push) begin
            pc_next = fetch_pc_q + PC_STEP;
        end else begin
            pc_next = fetch_pc_q;
        end

        if (redirect_i) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end

        // A new request only starts with room guaranteed for its data.
        issue = start_i && (count_next < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else begin
            fetch_pc_q <= pc_next;
            req_q      <= hold || issue;
            addr_q     <= hold ? addr_q : pc_next;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (hold && redirect_i) begin
                        state_q <= StDiscard;
                    end else if (!start_i && !hold) begin
                        state_q <= StIdle;
                    end
                end
                StDiscard: begin
                    if (!hold) begin
                        state_q <= start_i ? StRun : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign push_entry = '{pc: fetch_pc_q, inst: imem_data_i};

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .push_data_i (push_entry),
        .head_o      (head),
        .count_o     (count)
    );

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = (count != '0);
    assign inst_o       = head.inst;
    assign inst_pc_o    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with configurable ack
// latency, a sequential-PC reference stream as scoreboard, directed scenarios
// and a randomized phase.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b0;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int total = 0;
    int bad = 0;
    int pops = 0;
    int acks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .inst_valid_o  (inst_valid),
        .inst_o        (inst),
        .inst_pc_o     (inst_pc),
        .inst_ready_i  (ready)
    );

    // Memory model: ack after wait_cnt reaches the chosen latency (0 = same cycle).
    int unsigned lat_fixed = 0;
    bit          rand_lat = 1'b0;
    int unsigned rlat = 0;
    int unsigned wait_cnt = 0;

    assign imem_ack  = imem_req && (wait_cnt >= (rand_lat ? rlat : lat_fixed));
    assign imem_data = imem_addr ^ KEY;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (!imem_req || imem_ack) begin
            wait_cnt <= 0;
            if (imem_ack) rlat <= $urandom_range(0, 3);
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model + monitor. The expected delivery stream is simply
    // consecutive word addresses from the last reset or redirect target.
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    bit          prev_hold;
    logic [31:0] prev_addr;

    initial begin
        logic [31:0] e;
        exp_next  = RESET_PC;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_next  = RESET_PC;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("req_held", {31'b0, imem_req}, 32'd1);
                    check("addr_stable", imem_addr, prev_addr);
                end
                prev_hold = imem_req && !imem_ack;
                prev_addr = imem_addr;
                if (imem_req && imem_ack) acks++;
                if (!inst_valid) begin
                    check("empty_inst", inst, 32'h0);
                    check("empty_pc", inst_pc, 32'h0);
                end
                if (redirect) begin
                    exp_q.delete();
                    exp_next = redirect_pc & 32'hFFFF_FFFC;
                end else if (inst_valid && ready) begin
                    e = exp_q.pop_front();
                    check("head_pc", inst_pc, e);
                    check("head_inst", inst, e ^ KEY);
                    pops++;
                end
                while (exp_q.size() < 4) begin
                    exp_q.push_back(exp_next);
                    exp_next = exp_next + 32'd4;
                end
            end
        end
    end

    initial begin
        int p0;
        int a0;

        // Reset state
        tick();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Streaming: ack tied high, ready high -> one instruction per cycle
        lat_fixed = 0;
        ready = 1'b1;
        start = 1'b1;
        repeat (5) tick();
        p0 = pops;
        repeat (10) tick();
        check("stream_rate", pops - p0, 32'd10);

        // Fill: drain, restart at 0 with decode stalled
        start = 1'b0;
        repeat (6) tick();
        ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        a0 = acks;
        start = 1'b1;
        repeat (8) tick();
        check("full_acks", acks - a0, DEPTH);
        check("full_req", {31'b0, imem_req}, 32'd0);
        check("full_head", inst_pc, 32'h0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("refill_req", {31'b0, imem_req}, 32'd1);
        check("refill_addr", imem_addr, 32'h10);
        repeat (3) tick();
        check("refill_acks", acks - a0, DEPTH + 1);
        ready = 1'b1;
        repeat (8) tick();

        // Three-cycle ack latency
        lat_fixed = 2;
        repeat (10) tick();
        p0 = pops;
        repeat (30) tick();
        check("slow_rate", pops - p0, 32'd10);

        // Redirect while the request for 0x8 is outstanding
        start = 1'b0;
        repeat (8) tick();
        lat_fixed = 5;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 60 && !(imem_req && imem_addr == 32'h8); i++) tick();
        check("req8_seen", {31'b0, imem_req && imem_addr == 32'h8}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20 && !(imem_req && imem_ack); i++) tick();
        check("discard_ack_seen", {31'b0, imem_req && imem_ack}, 32'd1);
        tick();
        check("post_discard_req", {31'b0, imem_req}, 32'd1);
        check("post_discard_addr", imem_addr, 32'h0000_0100);
        repeat (20) tick();

        // Redirect in the same cycle as an ack, three entries buffered
        start = 1'b0;
        repeat (12) tick();
        lat_fixed = 0;
        ready = 1'b0;
        a0 = acks;
        start = 1'b1;
        for (int i = 0; i < 20 && (acks - a0) < 3; i++) tick();
        check("three_acks", acks - a0, 32'd3);
        check("ack_now", {31'b0, imem_req && imem_ack}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick();
        redirect = 1'b0;
        check("flush_valid", {31'b0, inst_valid}, 32'd0);
        check("flush_req", {31'b0, imem_req}, 32'd1);
        check("flush_addr", imem_addr, 32'h0000_2000);
        ready = 1'b1;
        repeat (6) tick();

        // PC wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20 && !(imem_req && imem_ack && imem_addr == 32'hFFFF_FFFC); i++)
            tick();
        check("top_req_seen", {31'b0, imem_req && imem_addr == 32'hFFFF_FFFC}, 32'd1);
        tick();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_req", {31'b0, imem_req}, 32'd1);
        repeat (6) tick();

        // Randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 800; i++) begin
            redirect = ($urandom_range(0, 19) == 0);
            if (redirect) redirect_pc = $urandom;
            ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 29) != 0);
            tick();
        end
        redirect = 1'b0;
        start = 1'b1;
        ready = 1'b1;
        rand_lat = 1'b0;
        repeat (10) tick();

        // Reset in the middle of an outstanding request
        lat_fixed = 6;
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        check("pre_reset_req", {31'b0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_addr", imem_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat_fixed = 0;
        p0 = pops;
        repeat (12) tick();
        check("post_reset_progress", {31'b0, (pops - p0) >= 8}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
